q_update_pipe: RTL and testbench

Q_UPDATE_PIPE -- requirements
Module: q_update_pipe

---
 rtl/q_update_pipe.sv | 137 +++++++++++++
 tb/tb_q_update_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_update_pipe.sv
// Three-stage pipelined Q-learning update engine with an internal 28-entry Q-table.
// Same-key requests are serialised by in_ready; the write stage bypasses into a same-edge accept.
module q_update_pipe #(
    parameter int ALPHA_SH = 2,
    parameter int GAMMA_SH = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  Sn,
    input  logic [1:0]  An,
    input  logic [13:0] Rn,
    input  logic [13:0] maxQn_SnP1,
    output logic        out_valid,
    output logic [13:0] Qn_out,
    output logic [2:0]  Sn_out
);

    localparam int NENT = 28;

    logic [13:0] tbl_q [NENT];

    logic               v1_q, v2_q, v3_q;
    logic [4:0]         key1_q, key2_q, key3_q;
    logic [13:0]        r1_q, r2_q;
    logic [13:0]        qold1_q, qold2_q, qold3_q;
    logic [13:0]        mq2_q;
    logic signed [16:0] d3_q;

    logic        out_valid_q;
    logic [13:0] qn_q;
    logic [2:0]  sn_q;

    logic [4:0]         key_in;
    logic               accept;
    logic               v1_d;
    logic [13:0]        qold_d;
    logic [13:0]        g2;
    logic [14:0]        t2;
    logic signed [16:0] d2;
    logic signed [16:0] sh3;
    logic signed [17:0] sum3;
    logic [13:0]        qnew3;

    assign key_in   = {Sn, An};
    assign in_ready = !((v1_q && key1_q == key_in) ||
                        (v2_q && key2_q == key_in));
    assign accept   = in_valid && in_ready;
    assign v1_d     = accept && (Sn != 3'd7);

    // Stage 2 arithmetic: target and temporal-difference error
    assign g2 = mq2_q - (mq2_q >> GAMMA_SH);
    assign t2 = {1'b0, r2_q} + {1'b0, g2};
    assign d2 = $signed({2'b00, t2}) - $signed({3'b000, qold2_q});

    // Stage 3 arithmetic: scaled correction with saturation
    assign sh3  = d3_q >>> ALPHA_SH;
    assign sum3 = $signed({4'b0000, qold3_q}) + $signed({sh3[16], sh3});

    always_comb begin
        qnew3 = sum3[13:0];
        if (sum3 < 0) begin
            qnew3 = 14'd0;
        end else if (sum3 > 18'sd16383) begin
            qnew3 = 14'd16383;
        end
    end

    always_comb begin
        qold_d = 14'd0;
        if (v3_q && key3_q == key_in) begin
            qold_d = qnew3;
        end else if (Sn != 3'd7) begin
            qold_d = tbl_q[key_in];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NENT; i++) begin
                tbl_q[i] <= 14'd0;
            end
        end else if (v3_q) begin
            for (int i = 0; i < NENT; i++) begin
                if (key3_q == 5'(i)) begin
                    tbl_q[i] <= qnew3;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            key1_q      <= '0;
            key2_q      <= '0;
            key3_q      <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            qold1_q     <= '0;
            qold2_q     <= '0;
            qold3_q     <= '0;
            mq2_q       <= '0;
            d3_q        <= '0;
            out_valid_q <= 1'b0;
            qn_q        <= '0;
            sn_q        <= '0;
        end else begin
            v1_q <= v1_d;
            if (accept) begin
                key1_q  <= key_in;
                r1_q    <= Rn;
                qold1_q <= qold_d;
            end
            v2_q    <= v1_q;
            key2_q  <= key1_q;
            r2_q    <= r1_q;
            qold2_q <= qold1_q;
            mq2_q   <= maxQn_SnP1;
            v3_q    <= v2_q;
            key3_q  <= key2_q;
            qold3_q <= qold2_q;
            d3_q    <= d2;
            out_valid_q <= v3_q;
            qn_q        <= v3_q ? qnew3 : 14'd0;
            sn_q        <= v3_q ? key3_q[4:2] : 3'd0;
        end
    end

    assign out_valid = out_valid_q;
    assign Qn_out    = qn_q;
    assign Sn_out    = sn_q;

endmodule

// File: tb/tb_q_update_pipe.sv
// Randomised and directed bench for q_update_pipe against an arithmetic Q-learning model.
module tb_q_update_pipe;

    localparam int AS = 2;
    localparam int GS = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  Sn = '0;
    logic [1:0]  An = '0;
    logic [13:0] Rn = '0;
    logic [13:0] maxQn_SnP1 = '0;
    logic        out_valid;
    logic [13:0] Qn_out;
    logic [2:0]  Sn_out;

    q_update_pipe #(.ALPHA_SH(AS), .GAMMA_SH(GS)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .Sn(Sn), .An(An), .Rn(Rn), .maxQn_SnP1(maxQn_SnP1),
        .out_valid(out_valid), .Qn_out(Qn_out), .Sn_out(Sn_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic [2:0]  s;
        logic [1:0]  a;
        logic [13:0] r;
        logic [13:0] mq;
    } req_t;

    typedef struct {
        int s;
        int q;
        int cyc;
    } ent_t;

    req_t rq[$];
    ent_t exq[$];
    ent_t obq[$];
    int   model[28];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stalls = 0;
    int   idle_bad = 0;
    int   pend_mq = 0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (out_valid) begin
            obq.push_back('{int'(Sn_out), int'(Qn_out), cyc});
        end else if (Qn_out !== 14'd0 || Sn_out !== 3'd0) begin
            idle_bad = idle_bad + 1;
        end
    end

    function automatic int model_upd(input int qold, input int r, input int mq);
        int g, t, d, sh, qn;
        g = mq - (mq / (1 << GS));
        t = r + g;
        d = t - qold;
        if (d >= 0) sh = d / (1 << AS);
        else sh = -((-d + (1 << AS) - 1) / (1 << AS));
        qn = qold + sh;
        if (qn < 0) qn = 0;
        if (qn > 16383) qn = 16383;
        return qn;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 28; i++) model[i] = 0;
    endfunction

    task automatic push(input int s, input int a, input int r, input int mq);
        rq.push_back('{1'b1, 3'(s), 2'(a), 14'(r), 14'(mq)});
    endtask

    task automatic push_bubble();
        rq.push_back('{1'b0, 3'd0, 2'd0, 14'd0, 14'd0});
    endtask

    // Presents the queued requests; caller sits just after a negedge
    task automatic drive();
        int   budget;
        logic rdy;
        int   key, qn;
        budget = 0;
        stalls = 0;
        while (rq.size() > 0 && budget < 2000) begin
            in_valid   = rq[0].v;
            Sn         = rq[0].s;
            An         = rq[0].a;
            Rn         = rq[0].r;
            maxQn_SnP1 = 14'(pend_mq);
            #1 rdy = in_ready;
            @(posedge CLK);
            pend_mq = int'($urandom_range(0, 16383));
            if (!rq[0].v) begin
                rq.delete(0);
            end else if (rdy) begin
                if (rq[0].s != 3'd7) begin
                    key = int'(rq[0].s) * 4 + int'(rq[0].a);
                    qn = model_upd(model[key], int'(rq[0].r), int'(rq[0].mq));
                    model[key] = qn;
                    exq.push_back('{int'(rq[0].s), qn, cyc + 1});
                end
                pend_mq = int'(rq[0].mq);
                rq.delete(0);
            end else begin
                stalls++;
            end
            budget++;
            @(negedge CLK);
        end
        in_valid   = 1'b0;
        maxQn_SnP1 = 14'(pend_mq);
        if (rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: %0d requests left, required 0", rq.size());
            rq.delete();
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || Qn_out !== 14'd0 || Sn_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b q=%0d s=%0d, required 0 0 0",
                     out_valid, Qn_out, Sn_out);
        end
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic();
        push(2, 1, 800, 1600);
        drive();
        settle();
        checks++;
        if (obq.size() !== 1 || exq.size() !== 1) begin
            errors++;
            $display("FAIL basic_count: got %0d outputs, required 1", obq.size());
        end else begin
            checks++;
            if (obq[0].q !== 550 || obq[0].s !== 2) begin
                errors++;
                $display("FAIL basic_value: got q=%0d s=%0d, required q=550 s=2",
                         obq[0].q, obq[0].s);
            end
            checks++;
            if (obq[0].cyc - exq[0].cyc !== 3) begin
                errors++;
                $display("FAIL basic_latency: got %0d, required 3",
                         obq[0].cyc - exq[0].cyc);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_decrease();
        push(3, 0, 4000, 0);
        push(3, 1, 4004, 0);
        push(3, 0, 0, 0);
        push(3, 1, 0, 0);
        drive();
        settle();
        checks++;
        if (obq.size() !== 4) begin
            errors++;
            $display("FAIL decrease_count: got %0d outputs, required 4", obq.size());
        end else begin
            checks++;
            if (obq[0].q !== 1000 || obq[1].q !== 1001) begin
                errors++;
                $display("FAIL decrease_preload: got %0d %0d, required 1000 1001",
                         obq[0].q, obq[1].q);
            end
            checks++;
            if (obq[2].q !== 750 || obq[3].q !== 750) begin
                errors++;
                $display("FAIL decrease_value: got %0d %0d, required 750 750",
                         obq[2].q, obq[3].q);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) push(5, 2, 16383, 16383);
        drive();
        settle();
        checks++;
        if (obq.size() !== exq.size() || obq.size() !== 5) begin
            errors++;
            $display("FAIL sat_count: got %0d outputs, required 5", obq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obq[i].q !== exq[i].q) begin
                    errors++;
                    $display("FAIL sat_step%0d: got %0d, required %0d",
                             i, obq[i].q, exq[i].q);
                end
            end
            checks++;
            if (obq[4].q !== 16383) begin
                errors++;
                $display("FAIL sat_clamp: got %0d, required 16383", obq[4].q);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_hazard();
        push(1, 1, 3000, 5000);
        push(1, 1, 2000, 7000);
        drive();
        settle();
        checks++;
        if (stalls !== 2) begin
            errors++;
            $display("FAIL hazard_stalls: got %0d, required 2", stalls);
        end
        checks++;
        if (obq.size() !== 2) begin
            errors++;
            $display("FAIL hazard_count: got %0d outputs, required 2", obq.size());
        end else begin
            checks++;
            if (obq[0].q !== exq[0].q || obq[1].q !== exq[1].q) begin
                errors++;
                $display("FAIL hazard_bypass: got %0d %0d, required %0d %0d",
                         obq[0].q, obq[1].q, exq[0].q, exq[1].q);
            end
            checks++;
            if (exq[1].cyc - exq[0].cyc !== 3) begin
                errors++;
                $display("FAIL hazard_accept_gap: got %0d, required 3",
                         exq[1].cyc - exq[0].cyc);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_stream();
        int bad;
        for (int k = 0; k < 28; k++) begin
            push(k / 4, k % 4, int'($urandom_range(0, 16383)),
                 int'($urandom_range(0, 16383)));
        end
        drive();
        settle();
        checks++;
        if (stalls !== 0) begin
            errors++;
            $display("FAIL stream_stalls: got %0d, required 0", stalls);
        end
        checks++;
        if (obq.size() !== 28 || exq.size() !== 28) begin
            errors++;
            $display("FAIL stream_count: got %0d outputs, required 28", obq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 28; i++) begin
                if (obq[i].q !== exq[i].q || obq[i].s !== exq[i].s ||
                    obq[i].cyc !== obq[0].cyc + i ||
                    obq[i].cyc - exq[i].cyc !== 3) begin
                    bad++;
                end
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL stream_order: %0d entries wrong, required 0", bad);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_random();
        int bad;
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 4) == 0) push_bubble();
            else push(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
        end
        drive();
        settle();
        checks++;
        if (obq.size() !== exq.size()) begin
            errors++;
            $display("FAIL random_count: got %0d outputs, required %0d",
                     obq.size(), exq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < obq.size(); i++) begin
                if (obq[i].q !== exq[i].q || obq[i].s !== exq[i].s ||
                    obq[i].cyc - exq[i].cyc !== 3) begin
                    bad++;
                end
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL random_values: %0d entries wrong, required 0", bad);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_reset_midflight();
        int bad;
        push(4, 0, 9000, 9000);
        push(4, 1, 8000, 8000);
        push(4, 2, 7000, 7000);
        drive();
        RST = 1'b1;
        exq.delete();
        model_clear();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got rdy=%b v=%b, required 1 0",
                     in_ready, out_valid);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        settle();
        checks++;
        if (obq.size() !== 0) begin
            errors++;
            $display("FAIL midreset_flush: got %0d outputs, required 0", obq.size());
        end
        obq.delete();
        for (int k = 0; k < 28; k++) push(k / 4, k % 4, 0, 0);
        drive();
        settle();
        checks++;
        if (obq.size() !== 28) begin
            errors++;
            $display("FAIL midreset_sweep_count: got %0d, required 28", obq.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 28; i++) if (obq[i].q !== 0) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL midreset_table: %0d nonzero entries, required 0", bad);
            end
        end
        obq.delete();
        exq.delete();
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL idle_outputs: %0d idle cycles nonzero, required 0", idle_bad);
        end
    endtask

    initial begin
        model_clear();
        @(negedge CLK);
        test_reset();
        test_basic();
        test_decrease();
        test_saturation();
        test_hazard();
        test_stream();
        test_random();
        test_reset_midflight();
        test_idle_outputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
